axi_master_v4_read_aligned: RTL and testbench

AXI4 read master for aligned, full-width bursts. It is the read-side companion of the aligned AXI4 write master. It takes a user request (byte address and byte length) and splits it into INCR bursts of at most 256 beats that never cross a 4 KB boundary. It returns the read data to the user through a registered valid/ready stream, in address order.

---
 rtl/axi_pkg.sv | 20 ++
 rtl/axi_burst_split.sv | 24 ++
 rtl/axi_master_v4_read_aligned.sv | 122 ++++++++++++
 tb/tb_axi_master_v4_read_aligned.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the read-master state encoding.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned AXI_4K_BYTES  = 4096;
  localparam int unsigned AXI_MAX_BEATS = 256;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } rd_state_e;

endpackage

// File: rtl/axi_burst_split.sv
// Combinational burst-length calculator: min(remaining, 256, beats to next 4 KB page) - 1.
module axi_burst_split
  import axi_pkg::*;
#(
  parameter int unsigned D_POWER = 3
) (
  input  logic [11:0] addr_i,
  input  logic [31:0] beats_i,
  output logic [7:0]  len_o
);

  logic [12:0] to_4k;
  logic [12:0] cap;
  logic [12:0] burst;

  always_comb begin
    to_4k = (13'(AXI_4K_BYTES) - {1'b0, addr_i}) >> D_POWER;
    cap   = (to_4k > 13'(AXI_MAX_BEATS)) ? 13'(AXI_MAX_BEATS) : to_4k;
    burst = (beats_i < {19'b0, cap}) ? beats_i[12:0] : cap;
    // burst is never zero when len_o is consumed; the caller skips empty requests
    len_o = 8'(burst - 13'd1);
  end

endmodule

// File: rtl/axi_master_v4_read_aligned.sv
// AXI4 read master: splits aligned requests into INCR bursts and streams data out in order.
module axi_master_v4_read_aligned
  import axi_pkg::*;
#(
  parameter int unsigned D_POWER = 3,
  parameter int unsigned D_WIDTH = 8 * (1 << D_POWER),
  parameter int unsigned B_WIDTH = 1 << D_POWER
) (
  input  logic               sys_clock,
  input  logic               async_reset,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_len,
  input  logic               i_req,
  output logic               or_busy,
  output logic               or_err,
  output logic [D_WIDTH-1:0] or_data,
  output logic               or_valid,
  input  logic               i_ready,
  output logic [31:0]        or_ar_addr,
  output logic [7:0]         or_ar_len,
  output logic [2:0]         o_ar_size,
  output logic [1:0]         o_ar_burst,
  output logic               or_ar_valid,
  input  logic               i_ar_ready,
  input  logic [D_WIDTH-1:0] i_r_data,
  input  logic [1:0]         i_r_resp,
  input  logic               i_r_last,
  input  logic               i_r_valid,
  output logic               o_r_ready
);

  localparam logic [31:0] ADDR_MASK = ~(32'(B_WIDTH) - 32'd1);

  rd_state_e   state_q;
  logic [31:0] r_addr_q;
  logic [31:0] r_beats_q;
  logic [7:0]  beat_cnt_q;
  logic [7:0]  burst_m1;
  logic [31:0] burst_beats;
  logic        r_hs;
  logic        resp_err;

  axi_burst_split #(
    .D_POWER (D_POWER)
  ) u_split (
    .addr_i  (r_addr_q[11:0]),
    .beats_i (r_beats_q),
    .len_o   (burst_m1)
  );

  assign o_ar_size   = 3'(D_POWER);
  assign o_ar_burst  = AXI_BURST_INCR;
  assign o_r_ready   = (state_q == S_DATA) & (~or_valid | i_ready);
  assign r_hs        = i_r_valid & o_r_ready;
  assign resp_err    = (i_r_resp == AXI_RESP_SLVERR) | (i_r_resp == AXI_RESP_DECERR);
  // the registered AR length is the burst being issued, so the step is taken from it
  assign burst_beats = 32'(or_ar_len) + 32'd1;

  always_ff @(posedge sys_clock or negedge async_reset) begin
    if (!async_reset) begin
      state_q     <= S_IDLE;
      r_addr_q    <= '0;
      r_beats_q   <= '0;
      beat_cnt_q  <= '0;
      or_busy     <= 1'b1;
      or_err      <= 1'b0;
      or_data     <= '0;
      or_valid    <= 1'b0;
      or_ar_addr  <= '0;
      or_ar_len   <= '0;
      or_ar_valid <= 1'b0;
    end else begin
      if (or_valid & i_ready & ~r_hs) begin
        or_valid <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (i_req) begin
            r_addr_q  <= i_addr & ADDR_MASK;
            r_beats_q <= i_len >> D_POWER;
            or_err    <= 1'b0;
            or_busy   <= 1'b1;
            state_q   <= S_ADDR;
          end else if (!or_valid) begin
            or_busy <= 1'b0;
          end
        end
        S_ADDR: begin
          if (r_beats_q == '0) begin
            state_q <= S_IDLE;
          end else if (!or_ar_valid) begin
            or_ar_valid <= 1'b1;
            or_ar_addr  <= r_addr_q;
            or_ar_len   <= burst_m1;
          end else if (i_ar_ready) begin
            or_ar_valid <= 1'b0;
            r_addr_q    <= r_addr_q + (burst_beats << D_POWER);
            r_beats_q   <= r_beats_q - burst_beats;
            beat_cnt_q  <= or_ar_len;
            state_q     <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_hs) begin
            or_data  <= i_r_data;
            or_valid <= 1'b1;
            if (resp_err || (i_r_last != (beat_cnt_q == 8'd0))) begin
              or_err <= 1'b1;
            end
            if (beat_cnt_q == 8'd0) begin
              state_q <= (r_beats_q != '0) ? S_ADDR : S_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q - 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_v4_read_aligned.sv
// Scoreboard bench: reference burst list and data stream from plain address arithmetic.
module tb_axi_master_v4_read_aligned;

  localparam int DP = 3;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   i_addr, i_len;
  logic          i_req;
  logic          or_busy, or_err, or_valid;
  logic [DW-1:0] or_data;
  logic          i_ready;
  logic [31:0]   or_ar_addr;
  logic [7:0]    or_ar_len;
  logic [2:0]    o_ar_size;
  logic [1:0]    o_ar_burst;
  logic          or_ar_valid, i_ar_ready;
  logic [DW-1:0] i_r_data;
  logic [1:0]    i_r_resp;
  logic          i_r_last, i_r_valid, o_r_ready;

  always #5 clk = ~clk;

  axi_master_v4_read_aligned #(.D_POWER(DP)) dut (
    .sys_clock   (clk),
    .async_reset (rst_n),
    .i_addr      (i_addr),
    .i_len       (i_len),
    .i_req       (i_req),
    .or_busy     (or_busy),
    .or_err      (or_err),
    .or_data     (or_data),
    .or_valid    (or_valid),
    .i_ready     (i_ready),
    .or_ar_addr  (or_ar_addr),
    .or_ar_len   (or_ar_len),
    .o_ar_size   (o_ar_size),
    .o_ar_burst  (o_ar_burst),
    .or_ar_valid (or_ar_valid),
    .i_ar_ready  (i_ar_ready),
    .i_r_data    (i_r_data),
    .i_r_resp    (i_r_resp),
    .i_r_last    (i_r_last),
    .i_r_valid   (i_r_valid),
    .o_r_ready   (o_r_ready)
  );

  int compared = 0;
  int mismatched = 0;

  logic [39:0] exp_ar[$];
  logic [63:0] exp_data[$];
  logic [31:0] salt = 32'h0;
  int          err_idx = -1;
  int          served = 0;
  int          dout_cnt = 0;
  bit          gap_en = 0;
  bit          rand_rdy = 0;
  bit          stall = 0;
  bit          exp_err = 0;

  typedef struct {
    logic [31:0] a;
    int          n;
  } burst_t;
  burst_t pend[$];
  int     pos = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ salt, ~a + salt};
  endfunction

  // AR and R monitors
  initial begin
    logic [39:0] e;
    logic [63:0] d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (or_ar_valid && i_ar_ready) begin
          if (exp_ar.size() == 0) fail_now("ar_unexpected", {or_ar_addr, 24'b0, or_ar_len});
          else begin
            e = exp_ar.pop_front();
            chk("ar_addr", {32'b0, or_ar_addr}, {32'b0, e[39:8]});
            chk("ar_len", {56'b0, or_ar_len}, {56'b0, e[7:0]});
          end
        end
        if (or_valid && i_ready) begin
          dout_cnt++;
          if (exp_data.size() == 0) fail_now("rdata_unexpected", or_data);
          else begin
            d = exp_data.pop_front();
            chk("rdata", or_data, d);
          end
        end
      end
    end
  end

  // Slave: serves accepted bursts in order with data derived from the beat address
  initial begin
    bit          ar_hs, r_hs;
    logic [31:0] cap_a;
    logic [7:0]  cap_l;
    logic [31:0] ba;
    i_r_valid = 0; i_r_data = '0; i_r_resp = 2'b00; i_r_last = 0; i_ar_ready = 1;
    forever begin
      @(negedge clk);
      ar_hs = or_ar_valid & i_ar_ready;
      cap_a = or_ar_addr;
      cap_l = or_ar_len;
      r_hs  = i_r_valid & o_r_ready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend.delete();
        pos = 0;
        i_r_valid = 0;
      end else begin
        if (ar_hs) pend.push_back('{a: cap_a, n: int'(cap_l) + 1});
        if (r_hs) begin
          served++;
          pos++;
          if (pos == pend[0].n) begin
            void'(pend.pop_front());
            pos = 0;
          end
          i_r_valid = 0;
        end
        i_ar_ready = gap_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (!i_r_valid && pend.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
          ba = pend[0].a + 32'(pos * 8);
          i_r_data  = pat(ba);
          i_r_last  = (pos == pend[0].n - 1);
          i_r_resp  = (served == err_idx) ? 2'b10 : 2'b00;
          i_r_valid = 1;
        end
      end
    end
  end

  initial begin
    i_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      i_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : !stall;
    end
  end

  task automatic wait_idle();
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!or_busy) break;
    end
    if (n == 2000) fail_now("idle_timeout", {63'b0, or_busy});
  endtask

  task automatic issue_req(input logic [31:0] addr, input logic [31:0] len, input int eidx);
    logic [31:0] a, beats, b, to4k, nb;
    wait_idle();
    beats = len >> 3;
    nb = beats;
    a = addr & ~32'h7;
    exp_err = (eidx >= 0) && (eidx < int'(beats));
    salt = $urandom;
    served = 0;
    err_idx = eidx;
    while (beats > 0) begin
      to4k = (32'd4096 - (a & 32'hFFF)) >> 3;
      b = beats;
      if (b > 256) b = 256;
      if (b > to4k) b = to4k;
      exp_ar.push_back({a, 8'(b - 1)});
      for (int i = 0; i < int'(b); i++) exp_data.push_back(pat(a + 32'(8 * i)));
      a = a + (b << 3);
      beats = beats - b;
    end
    @(posedge clk); #1;
    i_addr = addr; i_len = len; i_req = 1;
    @(posedge clk); #1;
    i_req = 0;
    @(negedge clk);
    chk("busy_on_accept", {63'b0, or_busy}, 64'd1);
    chk("err_clear", {63'b0, or_err}, 64'd0);
    chk("arvalid_n1", {63'b0, or_ar_valid}, 64'd0);
    if (nb > 0) begin
      @(negedge clk);
      chk("arvalid_n2", {63'b0, or_ar_valid}, 64'd1);
    end
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 20000; n++) begin
      @(negedge clk); #1;
      if (exp_ar.size() == 0 && exp_data.size() == 0 && !or_busy) break;
    end
    if (n == 20000) begin
      fail_now("done_timeout", {32'(exp_ar.size()), 32'(exp_data.size())});
      exp_ar.delete();
      exp_data.delete();
    end
    chk("err_flag", {63'b0, or_err}, {63'b0, exp_err});
    chk("rready_idle", {63'b0, o_r_ready}, 64'd0);
  endtask

  task automatic run_req(input logic [31:0] addr, input logic [31:0] len, input int eidx);
    issue_req(addr, len, eidx);
    wait_done();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, {63'b0, or_busy}, 64'd1);
    chk({tag, "_err"}, {63'b0, or_err}, 64'd0);
    chk({tag, "_valid"}, {63'b0, or_valid}, 64'd0);
    chk({tag, "_data"}, or_data, 64'd0);
    chk({tag, "_arvalid"}, {63'b0, or_ar_valid}, 64'd0);
    chk({tag, "_araddr"}, {32'b0, or_ar_addr}, 64'd0);
    chk({tag, "_arlen"}, {56'b0, or_ar_len}, 64'd0);
    chk({tag, "_rready"}, {63'b0, o_r_ready}, 64'd0);
  endtask

  initial begin
    int base, n;
    logic [31:0] ra, rl;
    int re;
    i_req = 0; i_addr = '0; i_len = '0; rst_n = 0;
    #12;
    chk_reset("rst");
    chk("ar_size", {61'b0, o_ar_size}, 64'd3);
    chk("ar_burst", {62'b0, o_ar_burst}, 64'd1);
    @(posedge clk); #3 rst_n = 1;

    run_req(32'h1000, 32'd64, -1);
    run_req(32'h0FF0, 32'd64, -1);

    issue_req(32'h0, 32'd4096, -1);
    @(posedge clk); #1;
    i_addr = 32'h9000; i_len = 32'd64; i_req = 1;
    @(posedge clk); #1;
    i_req = 0;
    wait_done();

    issue_req(32'h3000, 32'd128, -1);
    base = dout_cnt;
    for (n = 0; n < 500; n++) begin
      @(negedge clk); #1;
      if (dout_cnt >= base + 3) break;
    end
    if (n == 500) fail_now("bp_timeout", 64'(dout_cnt - base));
    stall = 1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rready", {63'b0, o_r_ready}, 64'd0);
      if (k == 4) stall = 0;
    end
    @(negedge clk);
    chk("bp_resume", {63'b0, o_r_ready}, 64'd1);
    wait_done();

    run_req(32'h5000, 32'd64, 2);
    run_req(32'h5100, 32'd32, -1);
    run_req(32'h6000, 32'd4, -1);

    issue_req(32'h4000, 32'd256, -1);
    repeat (8) @(posedge clk);
    #2 rst_n = 0;
    #1 chk_reset("midrst");
    exp_ar.delete();
    exp_data.delete();
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    run_req(32'h2000, 32'd8, -1);

    gap_en = 1;
    rand_rdy = 1;
    for (int t = 0; t < 20; t++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra = (ra & 32'hFFFF_F000) | (32'hFFF - 32'($urandom_range(0, 511)));
      rl = 32'($urandom_range(0, 3000));
      re = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(rl >> 3)) : -1;
      run_req(ra, rl, re);
    end
    rand_rdy = 0;
    gap_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
